// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer helpers and defaults
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 8;

    // Helpers work on a 32-bit container; callers zero-extend and truncate to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flop synchroniser with async active-low reset
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-domain pointer, full/almost_full, level and overflow controller
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_MARGIN = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_MARGIN);
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    localparam logic [PW-1:0] FULL_FLIP   = {2'b11, {(PW-2){1'b0}}};

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          wen_c;
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;

    sync_ff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr_gray),
        .q     (rsync)
    );

    always_comb begin
        wen_c    = winc & ~full_q;
        wbin_d   = wbin_q + PW'(wen_c);
        wgray_d  = PW'(bin2gray(32'(wbin_d)));
        rbin     = PW'(gray2bin(32'(rsync)));
        full_d   = (wgray_d == (rsync ^ FULL_FLIP));
        wlevel_d = wbin_d - rbin;
        afull_d  = (wlevel_d >= AFULL_LEVEL);
        // Setting wins over a simultaneous clear so no overflow event is ever lost.
        ovf_d    = (winc & full_q) | (ovf_q & ~overflow_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign wen         = wen_c;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wlevel      = wlevel_q;
    assign wptr_gray   = wgray_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - scoreboard bench for wptr_full_ctrl (ADDR_WIDTH=3, AFULL_MARGIN=2)
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] rptr_gray = 4'd0;
    logic [2:0] waddr;
    logic       wen;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
    logic [3:0] wptr_gray;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       wen;
        logic [2:0] waddr;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic [3:0] gray;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   rec_idx = 0;
    logic [3:0] gtab [16];

    wptr_full_ctrl #(
        .ADDR_WIDTH   (3),
        .AFULL_MARGIN (2),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .waddr        (waddr),
        .wen          (wen),
        .full         (full),
        .almost_full  (almost_full),
        .wlevel       (wlevel),
        .wptr_gray    (wptr_gray),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s rec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Each record describes the state after the previous edge, with this cycle's inputs applied.
    task automatic step(input logic r, input logic w, input logic [3:0] rg, input logic clr,
                        input logic e_wen, input logic [2:0] e_waddr, input logic e_full,
                        input logic e_af, input logic [3:0] e_lvl, input logic [3:0] e_gray,
                        input logic e_ovf);
        exp_t e;
        @(posedge wclk);
        #2;
        wrst_n       = r;
        winc         = w;
        rptr_gray    = rg;
        overflow_clr = clr;
        e = '{wen: e_wen, waddr: e_waddr, full: e_full, af: e_af,
              lvl: e_lvl, gray: e_gray, ovf: e_ovf};
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge wclk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wen",         rec_idx, 32'(wen),         32'(e.wen));
                chk("waddr",       rec_idx, 32'(waddr),       32'(e.waddr));
                chk("full",        rec_idx, 32'(full),        32'(e.full));
                chk("almost_full", rec_idx, 32'(almost_full), 32'(e.af));
                chk("wlevel",      rec_idx, 32'(wlevel),      32'(e.lvl));
                chk("wptr_gray",   rec_idx, 32'(wptr_gray),   32'(e.gray));
                chk("overflow",    rec_idx, 32'(overflow),    32'(e.ovf));
                rec_idx++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        gtab[0]  = 4'd0;  gtab[1]  = 4'd1;  gtab[2]  = 4'd3;  gtab[3]  = 4'd2;
        gtab[4]  = 4'd6;  gtab[5]  = 4'd7;  gtab[6]  = 4'd5;  gtab[7]  = 4'd4;
        gtab[8]  = 4'd12; gtab[9]  = 4'd13; gtab[10] = 4'd15; gtab[11] = 4'd14;
        gtab[12] = 4'd10; gtab[13] = 4'd11; gtab[14] = 4'd9;  gtab[15] = 4'd8;

        // Reset held, release, idle
        step(0, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);

        // Fill eight slots with the read pointer parked at 0
        for (int i = 0; i < 8; i++)
            step(1, 1, 4'd0, 0,  1, 3'(i), 0, (i >= 6), 4'(i), gtab[i], 0);
        // Ninth request while full: blocked, raises overflow on this edge
        step(1, 1, 4'd0, 0,  0, 3'd0, 1, 1, 4'd8, 4'd12, 0);

        // One read becomes visible after the synchroniser lag
        step(1, 0, 4'd1, 0,  0, 3'd0, 1, 1, 4'd8, 4'd12, 1);
        step(1, 0, 4'd1, 0,  0, 3'd0, 1, 1, 4'd8, 4'd12, 1);
        // Still full: write attempt and clear on the same edge, set must win
        step(1, 1, 4'd1, 1,  0, 3'd0, 1, 1, 4'd8, 4'd12, 1);
        step(1, 0, 4'd1, 1,  0, 3'd0, 0, 1, 4'd7, 4'd12, 1);
        step(1, 0, 4'd1, 0,  0, 3'd0, 0, 1, 4'd7, 4'd12, 0);

        // Clean reset, five writes, then a mid-fill reset
        step(0, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 4'd0, 0,  1, 3'(i), 0, 0, 4'(i), gtab[i], 0);
        step(1, 0, 4'd0, 0,  0, 3'd5, 0, 0, 4'd5, 4'd7, 0);
        step(0, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        step(1, 1, 4'd0, 0,  1, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd1, 0, 0, 4'd1, 4'd1, 0);

        // Wrap: 16 writes with the reader tracking, level settles at the sync lag
        step(0, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);
        for (int k = 0; k < 16; k++)
            step(1, 1, gtab[k], 0,  1, 3'(k % 8), 0, 0, 4'((k < 3) ? k : 3), gtab[k], 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd3, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd2, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd1, 4'd0, 0);
        step(1, 0, 4'd0, 0,  0, 3'd0, 0, 0, 4'd0, 4'd0, 0);

        @(posedge wclk);
        @(posedge wclk);
        chk("scoreboard_drained", rec_idx, 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
